// File: rtl/ctrl_seq_param.sv
// Multi-cycle control sequencer for the register-file/ALU datapath.
// One instruction per valid/ready handshake; all outputs except instr_ready are registered.
module ctrl_seq_param #(
  parameter int NREG      = 8,
  parameter int LOAD_WAIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  output logic            instr_ready,
  output logic            done,
  output logic            illegal,
  output logic            ext_data_en,
  output logic            ext_data_low_reg_en,
  output logic [NREG-1:0] reg_in_en,
  output logic [NREG-1:0] reg_out_en,
  output logic            alu_reg_en,
  output logic [1:0]      alu_sel,
  output logic            alu_out_en,
  output logic            g_reg_en
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD2 = 3'd3,
    S_MOV   = 3'd4,
    S_ALU_A = 3'd5,
    S_ALU_B = 3'd6,
    S_ALU_G = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_MOV  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;

  localparam int         WAIT_LAST_I = (LOAD_WAIT > 32'sd0) ? (LOAD_WAIT - 32'sd1) : 32'sd0;
  localparam logic [3:0] WAIT_LAST   = 4'(WAIT_LAST_I);
  localparam logic       HAS_WAIT    = (LOAD_WAIT > 32'sd0);
  localparam logic [4:0] NREG_LIM    = 5'(NREG);

  function automatic logic idx_ok(input logic [3:0] idx);
    return ({1'b0, idx} < NREG_LIM);
  endfunction

  function automatic logic instr_legal(input logic [3:0] op, input logic [3:0] rx,
                                       input logic [3:0] ry);
    logic ok;
    case (op)
      OP_NOP:                                 ok = 1'b1;
      OP_LOAD:                                ok = idx_ok(rx);
      OP_MOV, OP_ADD, OP_XOR, OP_SUB, OP_AND: ok = idx_ok(rx) && idx_ok(ry);
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) begin
      v[i] = (idx == 4'(i));
    end
    return v;
  endfunction

  function automatic logic [1:0] alu_code(input logic [3:0] op);
    logic [1:0] c;
    case (op)
      OP_ADD:  c = 2'd0;
      OP_XOR:  c = 2'd1;
      OP_SUB:  c = 2'd2;
      OP_AND:  c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  state_t          state_r, state_s;
  logic [3:0]      op_r, op_s, rx_r, rx_s, ry_r, ry_s, cnt_r, cnt_s;
  logic            accept_s, done_s, illegal_s;
  logic            ext_data_en_s, ext_data_low_reg_en_s, alu_reg_en_s, alu_out_en_s, g_reg_en_s;
  logic [NREG-1:0] reg_in_en_s, reg_out_en_s;
  logic [1:0]      alu_sel_s;
  logic            instr_unused_s;

  assign instr_ready    = (state_r == S_IDLE) && !rst;
  assign accept_s       = instr_valid && instr_ready;
  assign instr_unused_s = ^instr[3:0];

  // Next state and field latch; outputs are then decoded from the next state so they register in step.
  always_comb begin
    state_s   = state_r;
    op_s      = op_r;
    rx_s      = rx_r;
    ry_s      = ry_r;
    cnt_s     = cnt_r;
    done_s    = 1'b0;
    illegal_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          op_s = instr[15:12];
          rx_s = instr[11:8];
          ry_s = instr[7:4];
          if (!instr_legal(instr[15:12], instr[11:8], instr[7:4])) begin
            done_s    = 1'b1;
            illegal_s = 1'b1;
          end else begin
            case (instr[15:12])
              OP_LOAD:                        state_s = S_LOAD1;
              OP_MOV:                         state_s = S_MOV;
              OP_ADD, OP_XOR, OP_SUB, OP_AND: state_s = S_ALU_A;
              default:                        done_s  = 1'b1;
            endcase
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD1: begin
        cnt_s   = 4'd0;
        state_s = HAS_WAIT ? S_WAIT : S_LOAD2;
      end
      S_WAIT: begin
        if (cnt_r == WAIT_LAST) begin
          state_s = S_LOAD2;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      S_ALU_A: state_s = S_ALU_B;
      S_ALU_B: state_s = S_ALU_G;
      S_LOAD2, S_MOV, S_ALU_G: begin
        state_s = S_IDLE;
        done_s  = 1'b1;
      end
      default: state_s = S_IDLE;
    endcase

    ext_data_en_s         = 1'b0;
    ext_data_low_reg_en_s = 1'b0;
    reg_in_en_s           = {NREG{1'b0}};
    reg_out_en_s          = {NREG{1'b0}};
    alu_reg_en_s          = 1'b0;
    alu_sel_s             = 2'd0;
    alu_out_en_s          = 1'b0;
    g_reg_en_s            = 1'b0;
    case (state_s)
      S_LOAD1: ext_data_low_reg_en_s = 1'b1;
      S_LOAD2: begin
        ext_data_en_s = 1'b1;
        reg_in_en_s   = onehot(rx_s);
      end
      S_MOV: begin
        reg_in_en_s  = onehot(rx_s);
        reg_out_en_s = onehot(ry_s);
      end
      S_ALU_A: begin
        reg_out_en_s = onehot(rx_s);
        alu_reg_en_s = 1'b1;
      end
      S_ALU_B: begin
        reg_out_en_s = onehot(ry_s);
        alu_sel_s    = alu_code(op_s);
        g_reg_en_s   = 1'b1;
      end
      S_ALU_G: begin
        alu_out_en_s = 1'b1;
        reg_in_en_s  = onehot(rx_s);
      end
      default: alu_sel_s = 2'd0;
    endcase
  end

  // State, latched fields and registered outputs; reset aborts any instruction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r             <= S_IDLE;
      op_r                <= 4'd0;
      rx_r                <= 4'd0;
      ry_r                <= 4'd0;
      cnt_r               <= 4'd0;
      done                <= 1'b0;
      illegal             <= 1'b0;
      ext_data_en         <= 1'b0;
      ext_data_low_reg_en <= 1'b0;
      reg_in_en           <= {NREG{1'b0}};
      reg_out_en          <= {NREG{1'b0}};
      alu_reg_en          <= 1'b0;
      alu_sel             <= 2'd0;
      alu_out_en          <= 1'b0;
      g_reg_en            <= 1'b0;
    end else begin
      state_r             <= state_s;
      op_r                <= op_s;
      rx_r                <= rx_s;
      ry_r                <= ry_s;
      cnt_r               <= cnt_s;
      done                <= done_s;
      illegal             <= illegal_s;
      ext_data_en         <= ext_data_en_s;
      ext_data_low_reg_en <= ext_data_low_reg_en_s;
      reg_in_en           <= reg_in_en_s;
      reg_out_en          <= reg_out_en_s;
      alu_reg_en          <= alu_reg_en_s;
      alu_sel             <= alu_sel_s;
      alu_out_en          <= alu_out_en_s;
      g_reg_en            <= g_reg_en_s;
    end
  end

endmodule
